regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers (power of two, >=4).
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter NRD, default 4, read-port count.
REQ-004 SHALL have parameter NWR, default 2, write-port count; AW = log2(NREG).
REQ-005 SHALL have port clk  in  1  sole clock, all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port we  in  NWR  per-port write enable.
REQ-008 SHALL have port waddr  in  NWR*AW  flattened write addresses, port i at [i*AW +: AW].
REQ-009 SHALL have port wdata  in  NWR*DW  flattened write data.
REQ-010 SHALL have port raddr  in  NRD*AW  flattened read addresses.
REQ-011 SHALL have port rdata  out  NRD*DW  flattened read data, combinational.
REQ-012 SHALL have port rbusy  out  NRD  scoreboard pending bit for each raddr.
REQ-013 SHALL have port sb_set  in  1  mark sb_addr pending (producer issued).
REQ-014 SHALL have port sb_addr  in  AW  register being marked pending.
REQ-015 SHALL have port ready  out  1  high once clear sequence finished.

Function
REQ-016 SHALL hardwire register 0: reads return 0, writes ignored, never pending.
REQ-017 SHALL run FSM states INIT, READY; INIT clears storage one register per cycle, index 1 upward.
REQ-018 SHALL leave INIT after clearing index NREG-1; ready rises the following cycle (NREG-1 cycles after rst release).
REQ-019 SHALL, in INIT, ignore we and sb_set, drive rdata=0 and rbusy=0.
REQ-020 SHALL, in READY, write wdata[i] to waddr[i] on the clock edge when we[i]=1 and waddr[i]!=0.
REQ-021 SHALL resolve same-address writes from several ports by highest port index winning.
REQ-022 SHALL clear the pending bit of every register written in a cycle.
REQ-023 SHALL give sb_set priority over a same-cycle write clear on the same address (bit ends set).
REQ-024 SHALL return for a read of register k the stored value, combinational, zero additional latency.
REQ-025 SHALL never produce X on rdata for any in-range address after ready.

Reset
REQ-026 SHALL, on rst high, asynchronously force state INIT, clear index to 1, ready=0, all pending bits 0.
REQ-027 SHALL restart the full clear sequence if rst asserts mid-INIT or during READY; storage contents are undefined until re-cleared.
REQ-028 SHALL not reset the storage array itself (cleared only by the INIT sequence).

Configuration
REQ-029 SHALL honour macro REGFILE_BYPASS_EN.
REQ-030 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle write data to matching read ports (highest writing port wins) and report rbusy=0 for an address written this cycle unless sb_set targets it.
REQ-031 SHALL, without REGFILE_BYPASS_EN, return pre-edge stored values and registered pending bits only.

Structure
REQ-032 SHALL place the FSM state encoding (INIT, READY) and default parameter constants in shared package regfile_pkg.
REQ-033 SHALL implement the pending-bit array as sub-module regfile_sb (set/clear priority, per-port lookup).

Verification
REQ-034 SHALL cover reset/init: release rst, NREG=32 -> ready=0 for 31 cycles, then 1; all reads 0.
REQ-035 SHALL cover write/read: we[0]=1, waddr=5, wdata=32'hDEADBEEF -> next cycle raddr=5 reads 32'hDEADBEEF; write to r0 -> r0 reads 0.
REQ-036 SHALL cover port conflict: port0 writes r7=1, port1 writes r7=2 same cycle -> r7 reads 2.
REQ-037 SHALL cover scoreboard: sb_set r9 -> rbusy=1; write r9 -> rbusy=0; sb_set r9 with same-cycle write r9 -> rbusy stays 1.
REQ-038 SHALL cover bypass: write r3=32'h12345678 and read r3 same cycle -> rdata 32'h12345678 with REGFILE_BYPASS_EN, old value without.
REQ-039 SHALL cover mid-init reset: assert rst at init cycle 10 -> ready stays 0, sequence restarts, ready after 31 cycles from release.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the multi-ported register file.
//   - default parameter values for regfile_mp / regfile_mp_if / regfile_sb
//   - FSM state encoding (INIT clears storage, READY serves traffic)
package regfile_pkg;
  localparam int NREG_DEF = 32;
  localparam int DW_DEF   = 32;
  localparam int NRD_DEF  = 4;
  localparam int NWR_DEF  = 2;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle between a register-file client and regfile_mp.
//   we      NWR        per-port write enable
//   waddr   NWR*AW     write address, port i at [i*AW +: AW]
//   wdata   NWR*DW     write data,    port i at [i*DW +: DW]
//   raddr   NRD*AW     read address
//   rdata   NRD*DW     read data (combinational)
//   rbusy   NRD        pending bit of each raddr
//   sb_set  1          mark sb_addr pending
//   sb_addr AW         register being marked pending
//   ready   1          clear sequence finished
// master = client side, slave = register file side.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int NWR  = NWR_DEF
);
  localparam int AW = $clog2(NREG);

  logic [NWR-1:0]    we;
  logic [NWR*AW-1:0] waddr;
  logic [NWR*DW-1:0] wdata;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic [NRD-1:0]    rbusy;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic              ready;

  modport master (output we, waddr, wdata, raddr, sb_set, sb_addr,
                  input  rdata, rbusy, ready);
  modport slave  (input  we, waddr, wdata, raddr, sb_set, sb_addr,
                  output rdata, rbusy, ready);
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: pending-bit scoreboard, one bit per architectural register.
//   clk, rst     clock, async active-high reset (all bits cleared)
//   en_i         register file is READY; set/clear ignored otherwise
//   wr_en_i      per write port: qualified write this cycle (addr != 0)
//   waddr_i      per write port address
//   set_i        mark set_addr_i pending
//   set_addr_i   address to mark
//   raddr_i      per read port address
//   busy_o       per read port pending bit
// Config: REGFILE_BYPASS_EN makes busy_o reflect this cycle's writes/set.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int NWR  = NWR_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic [NWR-1:0]          wr_en_i,
  input  logic [NWR-1:0][AW-1:0]  waddr_i,
  input  logic                    set_i,
  input  logic [AW-1:0]           set_addr_i,
  input  logic [NRD-1:0][AW-1:0]  raddr_i,
  output logic [NRD-1:0]          busy_o
);
  logic [NREG-1:0] pend_q, pend_d;
  logic            set_ok;

  assign set_ok = en_i && set_i && (set_addr_i != '0);

  // Write clears first, set last: a producer issued this cycle wins.
  always_comb begin
    pend_d = pend_q;
    for (int w = 0; w < NWR; w++)
      if (en_i && wr_en_i[w]) pend_d[waddr_i[w]] = 1'b0;
    if (set_ok) pend_d[set_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;

  for (genvar r = 0; r < NRD; r++) begin : g_lane
    logic b;
`ifdef REGFILE_BYPASS_EN
    logic hit;
    always_comb begin
      hit = 1'b0;
      for (int w = 0; w < NWR; w++)
        if (en_i && wr_en_i[w] && waddr_i[w] == raddr_i[r]) hit = 1'b1;
      b = en_i && pend_q[raddr_i[r]];
      // written this cycle: only a same-cycle set keeps it busy
      if (hit) b = set_ok && (set_addr_i == raddr_i[r]);
    end
`else
    always_comb b = en_i && pend_q[raddr_i[r]];
`endif
    assign busy_o[r] = b;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / NWR-write register file with scoreboard.
//   clk   sole clock
//   rst   async active-high reset: back to INIT, pending bits cleared
//   bus   regfile_mp_if.slave (writes, reads, scoreboard set, ready)
// After reset the INIT state clears registers 1..NREG-1, one per cycle;
// ready rises once the last one is cleared. Register 0 is hardwired zero.
// The storage array itself has no reset.
// Config: REGFILE_BYPASS_EN forwards same-cycle write data to readers
// (highest writing port wins) and applies same-cycle scoreboard effects.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int NWR  = NWR_DEF
) (
  input logic        clk,
  input logic        rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  logic [0:0]              state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic                    ready;
  logic [NWR-1:0][AW-1:0]  wa;
  logic [NWR-1:0][DW-1:0]  wd;
  logic [NRD-1:0][AW-1:0]  ra;
  logic [NRD-1:0][DW-1:0]  rd;
  logic [NWR-1:0]          wr_en;
  logic [NRD-1:0]          busy;
  logic [DW-1:0]           mem_q [NREG];

  assign wa        = bus.waddr;
  assign wd        = bus.wdata;
  assign ra        = bus.raddr;
  assign ready     = (state_q == ST_READY);
  assign bus.ready = ready;
  assign bus.rdata = rd;
  assign bus.rbusy = busy;

  always_comb
    for (int w = 0; w < NWR; w++)
      wr_en[w] = ready && bus.we[w] && (wa[w] != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ST_INIT) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end

  // Entry 0 is never written; reads of address 0 are forced to zero.
  // Loop order makes the highest port win on an address collision.
  always_ff @(posedge clk)
    if (state_q == ST_INIT) mem_q[idx_q] <= '0;
    else
      for (int w = 0; w < NWR; w++)
        if (wr_en[w]) mem_q[wa[w]] <= wd[w];

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [DW-1:0] v;
    always_comb begin
      v = '0;
      if (ready && ra[r] != '0) begin
        v = mem_q[ra[r]];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NWR; w++)
          if (wr_en[w] && wa[w] == ra[r]) v = wd[w];
`endif
      end
    end
    assign rd[r] = v;
  end

  regfile_sb #(.NREG(NREG), .NRD(NRD), .NWR(NWR)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .en_i       (ready),
    .wr_en_i    (wr_en),
    .waddr_i    (wa),
    .set_i      (bus.sb_set),
    .set_addr_i (bus.sb_addr),
    .raddr_i    (ra),
    .busy_o     (busy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int NREG = 32;
  localparam int DW   = 32;
  localparam int NRD  = 4;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.NREG(NREG), .DW(DW), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(.NREG(NREG), .DW(DW), .NRD(NRD), .NWR(NWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: architectural contents and pending bits
  logic [DW-1:0] mdl   [NREG];
  bit            mpend [NREG];

  function automatic void mdl_clear();
    for (int i = 0; i < NREG; i++) begin mdl[i] = '0; mpend[i] = 1'b0; end
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = mdl[a];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (bus.we[w] && int'(bus.waddr[w*AW +: AW]) == a) v = bus.wdata[w*DW +: DW];
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input int a);
    logic b;
    if (a == 0) return 1'b0;
    b = mpend[a];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (bus.we[w] && int'(bus.waddr[w*AW +: AW]) == a)
        b = bus.sb_set && int'(bus.sb_addr) == a;
`endif
    return b;
  endfunction

  task automatic clear_in();
    bus.we = '0; bus.waddr = '0; bus.wdata = '0;
    bus.raddr = '0; bus.sb_set = 1'b0; bus.sb_addr = '0;
  endtask

  task automatic set_wr(input int p, input logic en, input int a, input logic [DW-1:0] d);
    bus.we[p] = en;
    bus.waddr[p*AW +: AW] = AW'(a);
    bus.wdata[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int p, input int a);
    bus.raddr[p*AW +: AW] = AW'(a);
  endtask

  // one rising edge with the model following the architectural rules,
  // back at the falling edge afterwards
  task automatic tick();
    @(posedge clk);
    for (int w = 0; w < NWR; w++) begin
      int a;
      a = int'(bus.waddr[w*AW +: AW]);
      if (bus.we[w] && a != 0) begin
        mdl[a] = bus.wdata[w*DW +: DW];
        mpend[a] = 1'b0;
      end
    end
    if (bus.sb_set && bus.sb_addr != '0) mpend[bus.sb_addr] = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    clear_in();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.rbusy !== '0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b rbusy=%b want 0/0", bus.ready, bus.rbusy);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < NREG - 1; c++) begin
      // garbage traffic during INIT must be ignored
      bus.we = NWR'($urandom); bus.waddr = $urandom; bus.wdata = $urandom;
      bus.raddr = $urandom; bus.sb_set = 1'b1; bus.sb_addr = AW'($urandom_range(1, NREG-1));
      #1;
      checks++;
      if (bus.ready !== 1'b0 || bus.rdata !== '0 || bus.rbusy !== '0) begin
        errors++; bad++;
        if (bad < 4)
          $display("FAIL init_cycle%0d: ready=%b rdata=%h rbusy=%b want 0", c, bus.ready, bus.rdata, bus.rbusy);
      end
      @(negedge clk);
    end
    clear_in();
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_rise: ready=%b want 1 after %0d cycles", bus.ready, NREG-1);
    end
    mdl_clear();
    @(negedge clk);
    for (int g = 0; g < NREG / NRD; g++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, g*NRD + p);
      #1;
      checks++;
      if (bus.rdata !== '0 || bus.rbusy !== '0) begin
        errors++;
        $display("FAIL init_zero grp%0d: rdata=%h rbusy=%b want 0", g, bus.rdata, bus.rbusy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write_read();
    clear_in();
    set_wr(0, 1'b1, 5, 32'hDEADBEEF);
    tick();
    clear_in();
    set_rd(0, 5); set_rd(3, 5);
    #1;
    checks++;
    if (bus.rdata[0 +: DW] !== 32'hDEADBEEF || bus.rdata[3*DW +: DW] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd_r5: p0=%h p3=%h want deadbeef", bus.rdata[0 +: DW], bus.rdata[3*DW +: DW]);
    end
    set_wr(1, 1'b1, 0, 32'hFFFF_FFFF);
    set_rd(1, 0);
    tick();
    clear_in();
    set_rd(1, 0);
    #1;
    checks++;
    if (bus.rdata[DW +: DW] !== '0 || bus.rbusy[1] !== 1'b0) begin
      errors++;
      $display("FAIL wr_r0: rdata=%h rbusy=%b want 0/0", bus.rdata[DW +: DW], bus.rbusy[1]);
    end
  endtask

  task automatic test_port_conflict();
    clear_in();
    set_wr(0, 1'b1, 7, 32'd1);
    set_wr(1, 1'b1, 7, 32'd2);
    tick();
    clear_in();
    set_rd(1, 7);
    #1;
    checks++;
    if (bus.rdata[DW +: DW] !== 32'd2) begin
      errors++;
      $display("FAIL conflict_r7: got %h want 2", bus.rdata[DW +: DW]);
    end
  endtask

  task automatic test_scoreboard();
    logic exp;
    clear_in();
    bus.sb_set = 1'b1; bus.sb_addr = AW'(9);
    tick();
    clear_in();
    set_rd(2, 9);
    #1;
    checks++;
    if (bus.rbusy[2] !== 1'b1) begin
      errors++; $display("FAIL sb_set_r9: rbusy=%b want 1", bus.rbusy[2]);
    end
    set_wr(1, 1'b1, 9, 32'hCAFE0009);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp = 1'b0;
`else
    exp = 1'b1;
`endif
    checks++;
    if (bus.rbusy[2] !== exp) begin
      errors++; $display("FAIL sb_wr_same_cycle: rbusy=%b want %b", bus.rbusy[2], exp);
    end
    tick();
    clear_in();
    set_rd(2, 9);
    #1;
    checks++;
    if (bus.rbusy[2] !== 1'b0 || bus.rdata[2*DW +: DW] !== 32'hCAFE0009) begin
      errors++;
      $display("FAIL sb_clr_r9: rbusy=%b rdata=%h want 0/cafe0009", bus.rbusy[2], bus.rdata[2*DW +: DW]);
    end
    bus.sb_set = 1'b1; bus.sb_addr = AW'(9);
    set_wr(0, 1'b1, 9, 32'h0000_0099);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp = 1'b1;
`else
    exp = 1'b0;
`endif
    checks++;
    if (bus.rbusy[2] !== exp) begin
      errors++; $display("FAIL sb_set_wr_comb: rbusy=%b want %b", bus.rbusy[2], exp);
    end
    tick();
    clear_in();
    set_rd(2, 9);
    bus.sb_set = 1'b1; bus.sb_addr = '0;
    tick();
    clear_in();
    set_rd(2, 9); set_rd(0, 0);
    #1;
    checks++;
    if (bus.rbusy[2] !== 1'b1 || bus.rbusy[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_priority: rbusy r9=%b r0=%b want 1/0", bus.rbusy[2], bus.rbusy[0]);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp;
    clear_in();
    set_wr(0, 1'b1, 3, 32'h1111_1111);
    tick();
    set_wr(0, 1'b1, 3, 32'h1234_5678);
    bus.we[1] = 1'b0;
    set_rd(0, 3);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp = 32'h1234_5678;
`else
    exp = 32'h1111_1111;
`endif
    checks++;
    if (bus.rdata[0 +: DW] !== exp) begin
      errors++; $display("FAIL bypass_r3: got %h want %h", bus.rdata[0 +: DW], exp);
    end
    tick();
    set_wr(0, 1'b1, 3, 32'hAAAA_0000);
    set_wr(1, 1'b1, 3, 32'hBBBB_0000);
    set_rd(3, 3);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp = 32'hBBBB_0000;
`else
    exp = 32'h1234_5678;
`endif
    checks++;
    if (bus.rdata[3*DW +: DW] !== exp) begin
      errors++; $display("FAIL bypass_2port: got %h want %h", bus.rdata[3*DW +: DW], exp);
    end
    tick();
    clear_in();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      for (int w = 0; w < NWR; w++)
        set_wr(w, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
      for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, 15));
      bus.sb_set  = ($urandom_range(0, 2) == 0);
      bus.sb_addr = AW'($urandom_range(0, 15));
      #1;
      for (int p = 0; p < NRD; p++) begin
        int a;
        a = int'(bus.raddr[p*AW +: AW]);
        checks++;
        if (bus.rdata[p*DW +: DW] !== exp_rd(a) || bus.rbusy[p] !== exp_busy(a)) begin
          errors++; bad++;
          if (bad < 6)
            $display("FAIL rand c%0d p%0d r%0d: rdata=%h busy=%b want %h/%b",
                     c, p, a, bus.rdata[p*DW +: DW], bus.rbusy[p], exp_rd(a), exp_busy(a));
        end
      end
      tick();
    end
    clear_in();
  endtask

  task automatic test_mid_init_reset();
    int bad;
    clear_in();
    set_rd(0, 9);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.rbusy !== '0) begin
      errors++; $display("FAIL async_rst: ready=%b rbusy=%b want 0/0", bus.ready, bus.rbusy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL mid_init_rst: ready=%b want 0", bus.ready);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < NREG - 1; c++) begin
      #1;
      checks++;
      if (bus.ready !== 1'b0) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL reinit_cycle%0d: ready=%b want 0", c, bus.ready);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL reinit_ready: ready=%b want 1", bus.ready);
    end
    mdl_clear();
    @(negedge clk);
    set_rd(0, 3); set_rd(1, 5); set_rd(2, 7); set_rd(3, 9);
    #1;
    checks++;
    if (bus.rdata !== '0 || bus.rbusy !== '0) begin
      errors++; $display("FAIL reinit_zero: rdata=%h rbusy=%b want 0", bus.rdata, bus.rbusy);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_clear();
    clear_in();
    test_reset();
    test_write_read();
    test_port_conflict();
    test_scoreboard();
    test_bypass();
    test_random();
    test_mid_init_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
